// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: two-master arbiter and sequencer for the shared memory-mapped
// I/O bus. Master 0 is the CPU load/store unit, master 1 a debug/DMA requester.
// A granted access drives the bus for WAIT_CYCLES+1 cycles, then returns a
// one-cycle ack (with captured read data) to the owning master.
// Optional feature macro: IO_BUS_ARB_RR_EN (round-robin on ties; default is
// fixed priority with master 0 winning).
module io_bus_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_rw,
    input  logic [1:0]  m0_size,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,

    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_rw,
    input  logic [1:0]  m1_size,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,

    output logic [31:0] bus_addr,
    inout  logic [31:0] bus_data,
    output logic        bus_rw,
    output logic [1:0]  bus_size,
    output logic        busy
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE_W = 2;
    localparam logic [SIZE_W-1:0] SIZE_IDLE = 2'b00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;

    // Transaction latched at grant; the bus is driven only from these.
    logic [DATA_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                rw_q,    rw_d;
    logic [SIZE_W-1:0]   size_q,  size_d;
    logic                owner_q, owner_d;
    logic                last_grant_q, last_grant_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;

    // Registered outputs and their next values.
    logic [SIZE_W-1:0]   bus_size_q, bus_size_d;
    logic                drv_q,      drv_d;
    logic                busy_q,     busy_d;
    logic                m0_ack_q,   m0_ack_d;
    logic                m1_ack_q,   m1_ack_d;
    logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;

    // Arbitration signals.
    logic                m0_valid_c;
    logic                m1_valid_c;
    logic                grant_sel_c;

    // A request with size 00 is never eligible for grant.
    always_comb begin
        m0_valid_c = m0_req && (m0_size != SIZE_IDLE);
        m1_valid_c = m1_req && (m1_size != SIZE_IDLE);
`ifdef IO_BUS_ARB_RR_EN
        // Ties go to whichever master did not complete the previous access.
        if (m0_valid_c && m1_valid_c) begin
            grant_sel_c = ~last_grant_q;
        end else begin
            grant_sel_c = ~m0_valid_c;
        end
`else
        // Fixed priority: master 0 wins whenever it has a valid request.
        grant_sel_c = ~m0_valid_c;
`endif
    end

    // Next-state, transaction latch and registered-output next values.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rw_d         = rw_q;
        size_d       = size_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;

        case (state_q)
            IDLE: begin
                if (m0_valid_c || m1_valid_c) begin
                    state_d = ACCESS;
                    owner_d = grant_sel_c;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    if (grant_sel_c) begin
                        addr_d  = m1_addr;
                        wdata_d = m1_wdata;
                        rw_d    = m1_rw;
                        size_d  = m1_size;
                    end else begin
                        addr_d  = m0_addr;
                        wdata_d = m0_wdata;
                        rw_d    = m0_rw;
                        size_d  = m0_size;
                    end
                end
            end

            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = RESP;
                    if (!rw_q) begin
                        if (owner_q) begin
                            m1_rdata_d = bus_data;
                        end else begin
                            m0_rdata_d = bus_data;
                        end
                    end
                end
            end

            RESP: begin
                state_d      = IDLE;
                last_grant_d = owner_q;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Bus and handshake outputs are registered, so derive them from the
        // state being entered so they line up with that state's cycles.
        bus_size_d = (state_d == ACCESS) ? size_d : SIZE_IDLE;
        drv_d      = (state_d == ACCESS) && rw_d;
        busy_d     = (state_d != IDLE);
        m0_ack_d   = (state_d == RESP) && !owner_d;
        m1_ack_d   = (state_d == RESP) &&  owner_d;
    end

    // State, latched transaction and registered outputs; reset drops any access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            rw_q         <= 1'b0;
            size_q       <= SIZE_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            bus_size_q   <= SIZE_IDLE;
            drv_q        <= 1'b0;
            busy_q       <= 1'b0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rw_q         <= rw_d;
            size_q       <= size_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            bus_size_q   <= bus_size_d;
            drv_q        <= drv_d;
            busy_q       <= busy_d;
            m0_ack_q     <= m0_ack_d;
            m1_ack_q     <= m1_ack_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    // Output mapping; bus_data is released whenever no write access is active.
    assign bus_addr = addr_q;
    assign bus_rw   = rw_q;
    assign bus_size = bus_size_q;
    assign bus_data = drv_q ? wdata_q : 32'bz;
    assign busy     = busy_q;
    assign m0_ack   = m0_ack_q;
    assign m1_ack   = m1_ack_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;

    // Only one master is ever acknowledged in a given cycle.
    a_one_ack: assert property (@(posedge clk) disable iff (rst) !(m0_ack && m1_ack));

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: directed master transactions, a small bus slave
// (switches at 0x8000_0000, LEDs on byte writes there, a constant at
// 0x8000_0004) and a scoreboard monitor that checks every ack it sees.
module tb_io_bus_arbiter;

    localparam int unsigned TB_WAIT = 1;
    localparam logic [31:0] PARK    = 32'hA5A5_5A5A;
    localparam logic [31:0] SW_ADDR = 32'h8000_0000;
    localparam logic [31:0] K_ADDR  = 32'h8000_0004;
    localparam logic [31:0] K_DATA  = 32'h1234_5678;
    localparam logic [9:0]  SW_VAL  = 10'h2A5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        m0_req = 1'b0, m0_rw = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic [1:0]  m0_size = 2'b00;
    logic [31:0] m0_rdata;
    logic        m0_ack;

    logic        m1_req = 1'b0, m1_rw = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic [1:0]  m1_size = 2'b00;
    logic [31:0] m1_rdata;
    logic        m1_ack;

    logic [31:0] bus_addr;
    wire  [31:0] bus_data;
    logic        bus_rw;
    logic [1:0]  bus_size;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        m;
        logic        rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    // Slave model state.
    logic [31:0] rd_q;
    logic [9:0]  ledr;

    io_bus_arbiter #(.WAIT_CYCLES(TB_WAIT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rw(m0_rw),
        .m0_size(m0_size), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rw(m1_rw),
        .m1_size(m1_size), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
        .bus_addr(bus_addr), .bus_data(bus_data), .bus_rw(bus_rw),
        .bus_size(bus_size), .busy(busy)
    );

    always #5 clk = ~clk;

    // Idle bus is parked to a known pattern by the bench; reads are served by the slave.
    assign bus_data = (bus_size == 2'b00) ? PARK : (!bus_rw ? rd_q : 32'bz);

    // Registered slave: read data captured on the first access edge, byte writes to LEDs.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
            ledr <= '0;
        end else if (bus_size != 2'b00) begin
            if (!bus_rw) begin
                if (bus_addr == SW_ADDR)     rd_q <= {22'b0, SW_VAL};
                else if (bus_addr == K_ADDR) rd_q <= K_DATA;
                else                         rd_q <= '0;
            end else if (bus_addr == SW_ADDR && bus_size == 2'b01) begin
                ledr[7:0] <= bus_data[7:0];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every ack must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (m0_ack && m1_ack) begin
                checks++;
                errors++;
                $display("FAIL dual_ack: m0_ack=1 m1_ack=1, expected at most one");
            end
            if (m0_ack || m1_ack) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: m0_ack=%0b m1_ack=%0b, expected none", m0_ack, m1_ack);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("ack_master", {31'b0, m1_ack}, {31'b0, mon_e.m});
                    if (mon_e.rd) check("rdata", mon_e.m ? m1_rdata : m0_rdata, mon_e.data);
                end
            end
        end
    end

    task automatic set_master(input bit m, input bit req, input logic [31:0] a,
                              input logic [31:0] wd, input bit rw, input logic [1:0] sz);
        if (m) begin
            m1_req = req; m1_addr = a; m1_wdata = wd; m1_rw = rw; m1_size = sz;
        end else begin
            m0_req = req; m0_addr = a; m0_wdata = wd; m0_rw = rw; m0_size = sz;
        end
    endtask

    // One transaction from a master; called at a negedge with the arbiter idle.
    task automatic do_txn(input bit m, input logic [31:0] a, input logic [31:0] wd,
                          input bit rw, input logic [1:0] sz, input logic [31:0] exp_rd,
                          input bit drop_early);
        int  cyc = 0;
        int  act = 0;
        bit  seen = 0;
        sb_q.push_back('{m: m, rd: !rw, data: exp_rd});
        set_master(m, 1'b1, a, wd, rw, sz);
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if ((m ? m1_ack : m0_ack) == 1'b1) begin
                seen = 1;
            end else if (bus_size == sz) begin
                act++;
                if (rw) check("wr_bus_data", bus_data, wd);
            end
            if (drop_early && cyc == 1) set_master(m, 1'b0, a, wd, rw, sz);
        end
        check("ack_seen", {31'b0, seen}, 32'd1);
        check("ack_latency", 32'(cyc), 32'(TB_WAIT + 2));
        check("access_cycles", 32'(act), 32'(TB_WAIT + 1));
        check("resp_bus_size", {30'b0, bus_size}, 32'd0);
        check("resp_bus_data", bus_data, PARK);
        set_master(m, 1'b0, a, wd, rw, sz);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int n;
        int cyc;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state.
        check("rst_bus_size", {30'b0, bus_size}, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_rw",   {31'b0, bus_rw}, 32'd0);
        check("rst_busy",     {31'b0, busy}, 32'd0);
        check("rst_acks",     {30'b0, m1_ack, m0_ack}, 32'd0);
        check("rst_m0_rdata", m0_rdata, 32'd0);
        check("rst_m1_rdata", m1_rdata, 32'd0);
        check("rst_bus_data", bus_data, PARK);

        // m0 word read of the switches.
        do_txn(1'b0, SW_ADDR, 32'd0, 1'b0, 2'b11, 32'h0000_02A5, 1'b0);
        check("m0_rdata_held", m0_rdata, 32'h0000_02A5);

        // m1 byte write to the LEDs.
        do_txn(1'b1, SW_ADDR, 32'h0000_00FF, 1'b1, 2'b01, 32'd0, 1'b0);
        check("ledr_byte", {24'b0, ledr[7:0]}, 32'h0000_00FF);

        // Reset in the second access cycle of an m0 write.
        set_master(1'b0, 1'b1, 32'h8000_0008, 32'hCAFE_F00D, 1'b1, 2'b11);
        @(negedge clk);
        check("rw_acc1_data", bus_data, 32'hCAFE_F00D);
        @(negedge clk);
        check("rw_acc2_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        set_master(1'b0, 1'b0, 32'h8000_0008, 32'hCAFE_F00D, 1'b1, 2'b11);
        #1;
        check("arst_bus_size", {30'b0, bus_size}, 32'd0);
        check("arst_bus_addr", bus_addr, 32'd0);
        check("arst_busy",     {31'b0, busy}, 32'd0);
        check("arst_bus_data", bus_data, PARK);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("arst_no_ack", {30'b0, m1_ack, m0_ack}, 32'd0);
        end

        // Illegal size is never granted.
        set_master(1'b0, 1'b1, SW_ADDR, 32'd0, 1'b0, 2'b00);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("ill_busy", {31'b0, busy}, 32'd0);
            check("ill_bus_size", {30'b0, bus_size}, 32'd0);
        end
        set_master(1'b0, 1'b0, SW_ADDR, 32'd0, 1'b0, 2'b00);
        @(negedge clk);

        // m1 read with the request withdrawn during access.
        do_txn(1'b1, K_ADDR, 32'd0, 1'b0, 2'b11, K_DATA, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("drop_no_regrant", {31'b0, busy}, 32'd0);
        end

        // Both masters requesting continuously for four transactions.
`ifdef IO_BUS_ARB_RR_EN
        sb_q.push_back('{m: 1'b0, rd: 1'b1, data: {22'b0, SW_VAL}});
        sb_q.push_back('{m: 1'b1, rd: 1'b1, data: K_DATA});
        sb_q.push_back('{m: 1'b0, rd: 1'b1, data: {22'b0, SW_VAL}});
        sb_q.push_back('{m: 1'b1, rd: 1'b1, data: K_DATA});
`else
        for (int i = 0; i < 4; i++) sb_q.push_back('{m: 1'b0, rd: 1'b1, data: {22'b0, SW_VAL}});
`endif
        set_master(1'b0, 1'b1, SW_ADDR, 32'd0, 1'b0, 2'b11);
        set_master(1'b1, 1'b1, K_ADDR,  32'd0, 1'b0, 2'b11);
        n = 0;
        cyc = 0;
        while (n < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (m0_ack || m1_ack) n++;
        end
        set_master(1'b0, 1'b0, SW_ADDR, 32'd0, 1'b0, 2'b11);
        set_master(1'b1, 1'b0, K_ADDR,  32'd0, 1'b0, 2'b11);
        check("arb_ack_count", 32'(n), 32'd4);

        repeat (6) @(negedge clk);
        check("arb_idle_after", {31'b0, busy}, 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
